// File: rtl/alu_pkg.sv
//==============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, control-byte constants and CRC helpers for alu_core_pipe.
// Revision : 1.0
//==============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b100;
    localparam logic [2:0] c_OP_SUB = 3'b101;

    localparam logic [7:0] c_CTL_ERR_DATA = 8'hC9;
    localparam logic [7:0] c_CTL_ERR_CRC  = 8'hA5;
    localparam logic [7:0] c_CTL_ERR_OP   = 8'h93;
    localparam logic [7:0] c_CTL_RESET    = 8'hFF;

    // Upper bound on CRC message length; messages are right-aligned in this field.
    localparam int c_CRC_MAX_W = 1024;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DATA = 2'd1,
        ERR_CRC  = 2'd2,
        ERR_OP   = 2'd3
    } err_kind_e;

    function automatic logic [3:0] crc4_calc(input logic [c_CRC_MAX_W-1:0] data,
                                             input int nbits);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        fb  = 1'b0;
        for (int i = c_CRC_MAX_W-1; i >= 0; i--) begin
            if (i < nbits) begin
                fb  = crc[3] ^ data[i];
                crc = {crc[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
            end
        end
        return crc;
    endfunction

    function automatic logic [2:0] crc3_calc(input logic [c_CRC_MAX_W-1:0] data,
                                             input int nbits);
        logic [2:0] crc;
        logic       fb;
        crc = 3'h0;
        fb  = 1'b0;
        for (int i = c_CRC_MAX_W-1; i >= 0; i--) begin
            if (i < nbits) begin
                fb  = crc[2] ^ data[i];
                crc = {crc[1:0], 1'b0} ^ (fb ? 3'h3 : 3'h0);
            end
        end
        return crc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_crc3_gen.sv
//==============================================================================
// Module   : alu_crc3_gen
// Brief    : Combinational CRC3 (x^3+x+1, init 0, MSB first) over DATA_W+5 bits.
// Revision : 1.0
//==============================================================================
`default_nettype none

module alu_crc3_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
)(
    input  logic [DATA_W+4:0] data,
    output logic [2:0]        crc
);

    assign crc = crc3_calc({{(c_CRC_MAX_W-DATA_W-5){1'b0}}, data}, DATA_W+5);

endmodule

`default_nettype wire

// File: rtl/alu_core_pipe.sv
//==============================================================================
// Module   : alu_core_pipe
// Brief    : Two-stage AND/OR/ADD/SUB core with CRC-checked input control byte,
//            CRC-protected status byte and saturating delivery counters.
// Revision : 1.0
//==============================================================================
`default_nettype none

module alu_core_pipe
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [7:0]        in_ctl,
    input  logic              in_err_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_c,
    output logic [7:0]        out_ctl,
    output logic [CNT_W-1:0]  ops_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam int               c_CRC4_W  = 2*DATA_W + 4;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_c;
    logic [3:0]        r_s1_flags;
    err_kind_e         r_s1_err;
    logic              r_out_valid;
    logic              r_out_good;
    logic [DATA_W-1:0] r_out_c;
    logic [7:0]        r_out_ctl;
    logic [CNT_W-1:0]  r_ops_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_s2_load;
    logic              w_in_ready;
    logic              w_out_xfer;
    logic [2:0]        w_op;
    logic              w_unused_ctl;
    logic [3:0]        w_crc4;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_c;
    logic              w_carry;
    logic              w_ovf;
    logic              w_op_bad;
    err_kind_e         w_err;
    logic [2:0]        w_crc3;
    logic [DATA_W-1:0] w_s2_c;
    logic [7:0]        w_s2_ctl;

    assign w_s2_load  = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_out_xfer = r_out_valid && out_ready;

    assign w_op         = in_ctl[6:4];
    assign w_unused_ctl = in_ctl[7];
    assign w_crc4 = crc4_calc({{(c_CRC_MAX_W-c_CRC4_W){1'b0}}, in_b, in_a, 1'b1, w_op}, c_CRC4_W);

    // The extra MSB of the difference is the unsigned borrow.
    assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign w_diff = {1'b0, in_a} - {1'b0, in_b};

    always_comb begin
        w_c      = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_op_bad = 1'b0;
        case (w_op)
            c_OP_AND: w_c = in_a & in_b;
            c_OP_OR:  w_c = in_a | in_b;
            c_OP_ADD: begin
                w_c     = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
                w_ovf   = (in_a[DATA_W-1] == in_b[DATA_W-1]) && (w_sum[DATA_W-1] != in_a[DATA_W-1]);
            end
            c_OP_SUB: begin
                w_c     = w_diff[DATA_W-1:0];
                w_carry = w_diff[DATA_W];
                w_ovf   = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (w_diff[DATA_W-1] != in_a[DATA_W-1]);
            end
            default:  w_op_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_err = ERR_NONE;
        if (in_err_data)              w_err = ERR_DATA;
        else if (w_crc4 != in_ctl[3:0]) w_err = ERR_CRC;
        else if (w_op_bad)            w_err = ERR_OP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_c     <= '0;
            r_s1_flags <= 4'h0;
            r_s1_err   <= ERR_NONE;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_c     <= w_c;
                r_s1_flags <= {w_carry, w_ovf, (w_c == '0), w_c[DATA_W-1]};
                r_s1_err   <= w_err;
            end
        end
    end

    alu_crc3_gen #(
        .DATA_W (DATA_W)
    ) u_crc3 (
        .data (      {r_s1_c, 1'b0, r_s1_flags}),
        .crc  (w_crc3)
    );

    always_comb begin
        w_s2_c   = r_s1_c;
        w_s2_ctl = {1'b0, r_s1_flags, w_crc3};
        case (r_s1_err)
            ERR_DATA: begin w_s2_c = '0; w_s2_ctl = c_CTL_ERR_DATA; end
            ERR_CRC:  begin w_s2_c = '0; w_s2_ctl = c_CTL_ERR_CRC;  end
            ERR_OP:   begin w_s2_c = '0; w_s2_ctl = c_CTL_ERR_OP;   end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_good  <= 1'b0;
            r_out_c     <= '0;
            r_out_ctl   <= c_CTL_RESET;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_good <= (r_s1_err == ERR_NONE);
                r_out_c    <= w_s2_c;
                r_out_ctl  <= w_s2_ctl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_out_good) begin
                if (r_ops_cnt != '1) r_ops_cnt <= r_ops_cnt + c_CNT_ONE;
            end else begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_c     = r_out_c;
    assign out_ctl   = r_out_ctl;
    assign ops_cnt   = r_ops_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_core_pipe.sv
//==============================================================================
// Module   : tb_alu_core_pipe
// Brief    : Self-checking bench for alu_core_pipe with a queue-based reference.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_alu_core_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [7:0]        in_ctl = 8'h00;
    logic              in_err_data = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_c;
    logic [7:0]        out_ctl;
    logic [CNT_W-1:0]  ops_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [DATA_W-1:0] c;
        logic [7:0]        ctl;
        int                acc;
    } exp_t;

    exp_t              q[$];
    int                m_ops = 0;
    int                m_errs = 0;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_c = '0;
    logic [7:0]        prev_ctl = 8'h00;

    alu_core_pipe #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ctl      (in_ctl),
        .in_err_data (in_err_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_c       (out_c),
        .out_ctl     (out_ctl),
        .ops_cnt     (ops_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^k divided by the generator, by polynomial long division.
    function automatic logic [3:0] crc_div(input logic [127:0] msg, input int n,
                                           input int k, input logic [4:0] poly);
        bit         bits [200];
        logic [3:0] rem;
        rem = 4'h0;
        for (int i = 0; i < n + k; i++) bits[i] = (i < n) ? msg[n-1-i] : 1'b0;
        for (int i = 0; i < n; i++)
            if (bits[i])
                for (int j = 0; j <= k; j++) bits[i+j] ^= poly[k-j];
        for (int m = 0; m < k; m++) rem[k-1-m] = bits[n+m];
        return rem;
    endfunction

    function automatic logic [3:0] crc4_of(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        return crc_div({60'b0, b, a, 1'b1, op}, 68, 4, 5'b10011);
    endfunction

    function automatic logic [7:0] mk_ctl(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        return {1'b0, op, crc4_of(a, b, op)};
    endfunction

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [7:0] ctl, input logic ed,
                                  output logic [31:0] c, output logic [7:0] octl);
        logic [2:0] op;
        longint     sa, sb, sr;
        logic       cy, ov;
        logic [3:0] fl, r3;
        op = ctl[6:4];
        c  = '0;
        sr = 0;
        if (ed) octl = 8'hC9;
        else if (crc4_of(a, b, op) != ctl[3:0]) octl = 8'hA5;
        else if (!(op inside {3'd0, 3'd1, 3'd4, 3'd5})) octl = 8'h93;
        else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            cy = 1'b0;
            ov = 1'b0;
            case (op)
                3'd0: c = a & b;
                3'd1: c = a | b;
                3'd4: begin
                    c  = a + b;
                    cy = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                    sr = sa + sb;
                    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                end
                default: begin
                    c  = a - b;
                    cy = a < b;
                    sr = sa - sb;
                    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                end
            endcase
            fl   = {cy, ov, (c == 32'h0), c[31]};
            r3   = crc_div({91'b0, c, 1'b0, fl}, 37, 3, 5'b01011);
            octl = {1'b0, fl, r3[2:0]};
        end
    endfunction

    // Reference: every accepted beat queued with its accept cycle; oldest beat is at the output.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] mc;
        logic [7:0]  mctl;
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_ctl", out_ctl, 8'hFF);
            check("rst_out_c", out_c, 0);
            check("rst_ops_cnt", ops_cnt, 0);
            check("rst_err_cnt", err_cnt, 0);
            q.delete();
            m_ops = 0;
            m_errs = 0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            check("ops_cnt", ops_cnt, m_ops);
            check("err_cnt", err_cnt, m_errs);
            check("out_valid", out_valid, q.size() > 0 && (cyc - q[0].acc >= 2));
            if (prev_stall) begin
                check("stall_out_c", out_c, prev_c);
                check("stall_out_ctl", out_ctl, prev_ctl);
            end
            if (out_valid && q.size() > 0) begin
                check("out_c", out_c, q[0].c);
                check("out_ctl", out_ctl, q[0].ctl);
                if (out_ready) begin
                    if (q[0].ctl[7]) m_errs++;
                    else m_ops++;
                    void'(q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = out_c;
            prev_ctl   = out_ctl;
            if (in_valid && in_ready) begin
                model(in_a, in_b, in_ctl, in_err_data, mc, mctl);
                e.c   = mc;
                e.ctl = mctl;
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Presents one beat and returns once it has been accepted; in_valid is left high.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                             input logic ed, output int c0);
        bit ok;
        in_valid    = 1'b1;
        in_a        = a;
        in_b        = b;
        in_ctl      = ctl;
        in_err_data = ed;
        ok = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never high, required within 50 cycles");
        end
        c0 = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send_expect(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                               input logic ed, input logic [31:0] exp_c, input logic [7:0] exp_ctl,
                               input logic [7:0] mask, input string name);
        int c0;
        bit got;
        send_beat(a, b, ctl, ed, c0);
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid never high, required 2 cycles after accept", name);
        end else begin
            check({name, "_latency"}, cyc - c0, 2);
            check({name, "_c"}, out_c, exp_c);
            check({name, "_ctl"}, out_ctl & mask, exp_ctl & mask);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mc;
        logic [7:0]  mctl;
        logic [7:0]  bctl;
        logic [2:0]  ops [8];
        logic [31:0] a, b;
        int          c0;

        ops = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b100, 3'b101, 3'b001, 3'b111};

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        check("model_crc4_and_zero", crc4_of(32'h0, 32'h0, 3'b000), 4'hB);
        model(32'h0, 32'h0, 8'h0B, 1'b0, mc, mctl);
        check("model_and_zero_ctl", mctl, 8'h16);
        model(32'hFFFF_FFFF, 32'h1, mk_ctl(3'b100, 32'hFFFF_FFFF, 32'h1), 1'b0, mc, mctl);
        check("model_add_wrap_ctl", mctl, 8'h53);

        send_expect(32'h0, 32'h0, 8'h0B, 1'b0, 32'h0, 8'h16, 8'hFF, "and_zero");
        check("ops_after_and", ops_cnt, 1);
        send_expect(32'hFFFF_FFFF, 32'h1, mk_ctl(3'b100, 32'hFFFF_FFFF, 32'h1), 1'b0,
                    32'h0, 8'h53, 8'hFF, "add_wrap");

        bctl = mk_ctl(3'b010, 32'h1234_5678, 32'h9ABC_DEF0);
        send_expect(32'h1234_5678, 32'h9ABC_DEF0, bctl, 1'b0, 32'h0, 8'h93, 8'hFF, "err_op");
        check("err_after_op", err_cnt, 1);
        send_expect(32'h1234_5678, 32'h9ABC_DEF0, bctl ^ 8'h01, 1'b0, 32'h0, 8'hA5, 8'hFF, "err_crc");
        send_expect(32'h1234_5678, 32'h9ABC_DEF0, bctl ^ 8'h01, 1'b1, 32'h0, 8'hC9, 8'hFF, "err_data");
        check("err_after_three", err_cnt, 3);
        check("ops_after_errs", ops_cnt, 2);

        send_expect(32'h8000_0000, 32'h1, mk_ctl(3'b101, 32'h8000_0000, 32'h1), 1'b0,
                    32'h7FFF_FFFF, 8'h20, 8'hF8, "sub_ovf");
        send_expect(32'h1, 32'h2, mk_ctl(3'b101, 32'h1, 32'h2), 1'b0,
                    32'hFFFF_FFFF, 8'h48, 8'hF8, "sub_borrow");

        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = (i == 4) ? 32'h7FFF_FFFF : $urandom;
            b = (i == 4) ? 32'h1 : $urandom;
            send_beat(a, b, mk_ctl(ops[i], a, b) ^ ((i == 6) ? 8'h01 : 8'h00), (i == 5), c0);
        end
        in_valid = 1'b0;
        in_err_data = 1'b0;
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("stream_drained", q.size(), 0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_beat(32'h11, 32'h22, mk_ctl(3'b001, 32'h11, 32'h22), 1'b0, c0);
        send_beat(32'h33, 32'h44, mk_ctl(3'b100, 32'h33, 32'h44), 1'b0, c0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_ctl", out_ctl, 8'hFF);
        check("async_rst_ops_cnt", ops_cnt, 0);
        check("async_rst_err_cnt", err_cnt, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_expect(32'h5, 32'h7, mk_ctl(3'b100, 32'h5, 32'h7), 1'b0,
                    32'hC, 8'h00, 8'hF8, "post_reset_add");
        check("ops_after_reset", ops_cnt, 1);

        repeat (3) @(posedge clk);
        check("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
